// File: rtl/dlx_ifetch.sv
// DLX instruction fetch: owns the fetch PC, captures combinational instruction
// memory data into a small head-ordered buffer, and hands words to decode.
module dlx_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(FIFO_DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   ent_pc [FIFO_DEPTH];
  logic [31:0]   ent_in [FIFO_DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] base;
  logic [IW-1:0] widx;
  logic          pop;
  logic          push;

  // Decode handshake: a word transfers on any cycle where if_valid and
  // id_ready are both high; if_valid never depends on id_ready.
  assign pop  = if_valid & id_ready;
  assign push = !br_taken && ((count < CW'(FIFO_DEPTH)) || pop);
  assign base = count - CW'(pop);
  assign widx = IW'(base);

  assign pc       = fpc;
  assign if_valid = (count != '0);
  assign if_instr = ent_in[0];
  assign if_pc    = ent_pc[0];
  assign if_npc   = ent_pc[0] + 32'd4;

  // Entry 0 is always the head; stale slots are only overwritten when a
  // valid word moves in, so the head outputs hold after the buffer empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= RESET_PC;
      count       <= '0;
      misalign    <= 1'b0;
      fetch_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_pc[i] <= '0;
        ent_in[i] <= '0;
      end
    end else begin
      misalign <= br_taken & (br_target[1:0] != 2'b00);
      if (pop) fetch_count <= fetch_count + 32'd1;
      if (br_taken) begin
        count <= '0;
        fpc   <= {br_target[31:2], 2'b00};
      end else begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          if (pop && ((i + 1) < int'(count))) begin
            ent_pc[i] <= ent_pc[i+1];
            ent_in[i] <= ent_in[i+1];
          end
        end
        if (push) begin
          ent_pc[widx] <= fpc;
          ent_in[widx] <= instr;
          fpc          <= fpc + 32'd4;
        end
        count <= base + CW'(push);
      end
    end
  end

endmodule

// File: tb/tb_dlx_ifetch.sv
// Bench for dlx_ifetch: directed phases followed by random redirects, stalls
// and resets, checked against a queue-based fetch model.
module tb_dlx_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic        id_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        misalign;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {26'd0, a[7:2]};
  endfunction

  assign instr = mem_word(pc);

  dlx_ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_npc(if_npc),
    .id_ready(id_ready), .br_taken(br_taken), .br_target(br_target),
    .misalign(misalign), .fetch_count(fetch_count)
  );

  // Scoreboard queues: expected decode transfers {addr, instr} and per-cycle
  // expected state {pc, valid, fetch_count, misalign}.
  logic [63:0] exp_q[$];
  logic [65:0] st_q[$];

  // Reference model: buffered words, fetch address, handshake count.
  logic [63:0] mq[$];
  logic [31:0] m_pc  = RESET_PC;
  logic [31:0] m_fc  = 32'h0;
  logic        m_mis = 1'b0;

  int checks = 0;
  int passed = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic rdy, input logic br, input logic [31:0] tgt, input logic rst);
    @(negedge clk);
    id_ready  = rdy;
    br_taken  = br;
    br_target = tgt;
    reset     = rst;
    st_q.push_back({m_pc, (mq.size() != 0), m_fc, m_mis});
    if (rst) begin
      mq.delete();
      m_pc  = RESET_PC;
      m_fc  = 32'h0;
      m_mis = 1'b0;
    end else begin
      if (rdy && mq.size() != 0) begin
        exp_q.push_back(mq.pop_front());
        m_fc = m_fc + 32'd1;
      end
      if (br) begin
        mq.delete();
        m_pc  = {tgt[31:2], 2'b00};
        m_mis = (tgt[1:0] != 2'b00);
      end else begin
        m_mis = 1'b0;
        if (mq.size() < DEPTH) begin
          mq.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compares state every cycle and transfers on each handshake.
  initial begin
    logic [65:0] s;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        check32("pc", pc, s[65:34]);
        check32("if_valid", {31'd0, if_valid}, {31'd0, s[33]});
        check32("fetch_count", fetch_count, s[32:1]);
        check32("misalign", {31'd0, misalign}, {31'd0, s[0]});
      end
      if (if_valid && id_ready && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL hs_extra: got transfer of pc %h, expected none at %0t", if_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check32("if_pc", if_pc, e[63:32]);
          check32("if_instr", if_instr, e[31:0]);
          check32("if_npc", if_npc, e[63:32] + 32'd4);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    logic        rdy;
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_instr", if_instr, 32'h0);
    check32("rst_if_npc", if_npc, 32'h4);

    run(6, 1'b1);                              // streaming
    run(5, 1'b0);                              // backpressure
    run(4, 1'b1);
    run(3, 1'b0);                              // fill, then redirect with pop
    cyc(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    run(4, 1'b1);
    cyc(1'b1, 1'b1, 32'h0000_0023, 1'b0);      // misaligned redirect
    run(3, 1'b1);
    cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);      // address wrap
    run(4, 1'b1);
    run(3, 1'b0);                              // full and stalled, then reset
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check32("mid_rst_if_pc", if_pc, 32'h0);
    check32("mid_rst_if_npc", if_npc, 32'h4);

    for (int k = 0; k < 600; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 79) == 0) cyc(1'b0, 1'b0, 32'h0, 1'b1);
      else cyc(rdy, ($urandom_range(0, 9) == 0), tgt, 1'b0);
    end
    run(3, 1'b0);
    @(negedge clk);
    #5;
    check32("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
